// File: rtl/fetch_refill.sv
// fetch_refill: instruction-cache line refill engine for the fetch pipeline.
//
// Takes a physical miss word address from fetch1, issues one wrapping,
// critical-word-first bus read of a full cache line, writes every beat into
// the icache CAM and hands the requested instruction back to fetch on the
// first (critical) beat. A kill drains the burst without validating the line.
// A bus error aborts the refill and, unless killed, raises an exception.
//
// Ports
//   clk_core, reset           core clock, async active-high reset
//   req_valid/req_ready/
//   req_addr                  miss request handshake, word address [28:2]
//   kill                      flush of the requesting fetch
//   busy                      refill in progress
//   insn_valid/insn           early-restart instruction delivery (1-cycle pulse)
//   exc                       bus error on a non-killed refill (1-cycle pulse)
//   cvalid/cready/cmd/addr    bus read command (cmd is always read)
//   rvalid/rready/rlast/rdata read data beats
//   error/eack                bus error and its acknowledge
//   cam_write_*               icache CAM data and tag/flag write ports
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no refill; accepting a new miss request
// CMD   | read command presented on the bus, waiting for cready
// DATA  | receiving beats; kill only suppresses delivery and line validation

module fetch_refill #(
   parameter  int LINE_WORDS = 4,
   localparam int OFF_W      = $clog2(LINE_WORDS)
) (
   input  logic        clk_core,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [26:0] req_addr,
   input  logic        kill,
   output logic        busy,
   output logic        insn_valid,
   output logic [31:0] insn,
   output logic        exc,
   output logic        cvalid,
   input  logic        cready,
   output logic        cmd,
   output logic [26:0] addr,
   input  logic        rvalid,
   output logic        rready,
   input  logic        rlast,
   input  logic [31:0] rdata,
   input  logic        error,
   output logic        eack,
   output logic [9:0]  cam_write_index,
   output logic        cam_write_req_data,
   output logic [31:0] cam_write_data,
   output logic        cam_write_req_tag_flags,
   output logic [16:0] cam_write_tag,
   output logic [1:0]  cam_write_flags
);

   // One spare bit so an over-long burst saturates instead of wrapping back
   // to zero and re-triggering the critical-word handling.
   localparam int CNT_W = OFF_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      CMD  = 3'b010,
      DATA = 3'b100
   } state_t;

   state_t             state_q, state_d;
   logic [26:0]        addr_q, addr_d;
   logic               killed_q, killed_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               beat;
   logic               first_beat;
   logic               live;
   logic [OFF_W-1:0]   offset;

   always_ff @(posedge clk_core or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         killed_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         killed_q <= killed_d;
         cnt_q    <= cnt_d;
      end
   end

   // Offset addition is OFF_W bits wide, so it wraps at the end of the line.
   assign offset          = addr_q[OFF_W-1:0] + cnt_q[OFF_W-1:0];
   assign cam_write_index = {addr_q[9:OFF_W], offset};
   assign cam_write_tag   = addr_q[26:10];
   assign cam_write_data  = rdata;
   assign addr            = addr_q;
   assign cmd             = 1'b1;
   assign busy            = (state_q != IDLE);

   assign beat       = (state_q == DATA) & rvalid;
   assign first_beat = (cnt_q == '0);
   // Refill still wanted by the pipeline and not failed this cycle.
   assign live       = ~killed_q & ~kill & ~error;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      killed_d = killed_q;
      cnt_d    = cnt_q;

      req_ready               = 1'b0;
      cvalid                  = 1'b0;
      rready                  = 1'b0;
      insn_valid              = 1'b0;
      insn                    = '0;
      exc                     = 1'b0;
      eack                    = 1'b0;
      cam_write_req_data      = 1'b0;
      cam_write_req_tag_flags = 1'b0;
      cam_write_flags         = 2'b00;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid & ~kill) begin
               state_d  = CMD;
               addr_d   = req_addr;
               killed_d = 1'b0;
               cnt_d    = '0;
            end
         end

         CMD: begin
            cvalid   = 1'b1;
            killed_d = killed_q | kill;
            if (error) begin
               state_d = IDLE;
            end else if (cready) begin
               state_d = DATA;
            end
         end

         DATA: begin
            rready   = 1'b1;
            killed_d = killed_q | kill;
            if (beat) begin
               cam_write_req_data = 1'b1;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
               // Invalidate the line before its first word is overwritten.
               if (first_beat) begin
                  cam_write_req_tag_flags = 1'b1;
                  cam_write_flags         = 2'b00;
                  if (live) begin
                     insn_valid = 1'b1;
                     insn       = rdata;
                  end
               end
               if (rlast) begin
                  state_d = IDLE;
                  // A short burst leaves the line invalid.
                  if (live & (cnt_q == CNT_LAST)) begin
                     cam_write_req_tag_flags = 1'b1;
                     cam_write_flags         = 2'b01;
                  end
               end
            end
            if (error) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_q != IDLE) && error) begin
         eack = 1'b1;
         exc  = ~killed_q & ~kill;
      end
   end

endmodule

// File: tb/tb_fetch_refill.sv
module tb_fetch_refill;

   logic        clk_core = 1'b0;
   logic        reset;
   logic        req_valid, kill, cready, rvalid, rlast, error;
   logic [26:0] req_addr;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;
   logic sel8 = 1'b0;

   always #5 clk_core = ~clk_core;

   logic        ready4, busy4, iv4, exc4, cv4, cmd4, rr4, eack4, wd4, wtf4;
   logic [31:0] insn4, wdat4;
   logic [26:0] addr4;
   logic [9:0]  idx4;
   logic [16:0] tag4;
   logic [1:0]  flg4;

   logic        ready8, busy8, iv8, exc8, cv8, cmd8, rr8, eack8, wd8, wtf8;
   logic [31:0] insn8, wdat8;
   logic [26:0] addr8;
   logic [9:0]  idx8;
   logic [16:0] tag8;
   logic [1:0]  flg8;

   fetch_refill #(.LINE_WORDS(4)) u4 (
      .clk_core(clk_core), .reset(reset),
      .req_valid(req_valid), .req_ready(ready4), .req_addr(req_addr),
      .kill(kill), .busy(busy4), .insn_valid(iv4), .insn(insn4), .exc(exc4),
      .cvalid(cv4), .cready(cready), .cmd(cmd4), .addr(addr4),
      .rvalid(rvalid), .rready(rr4), .rlast(rlast), .rdata(rdata),
      .error(error), .eack(eack4),
      .cam_write_index(idx4), .cam_write_req_data(wd4), .cam_write_data(wdat4),
      .cam_write_req_tag_flags(wtf4), .cam_write_tag(tag4), .cam_write_flags(flg4)
   );

   fetch_refill #(.LINE_WORDS(8)) u8 (
      .clk_core(clk_core), .reset(reset),
      .req_valid(req_valid), .req_ready(ready8), .req_addr(req_addr),
      .kill(kill), .busy(busy8), .insn_valid(iv8), .insn(insn8), .exc(exc8),
      .cvalid(cv8), .cready(cready), .cmd(cmd8), .addr(addr8),
      .rvalid(rvalid), .rready(rr8), .rlast(rlast), .rdata(rdata),
      .error(error), .eack(eack8),
      .cam_write_index(idx8), .cam_write_req_data(wd8), .cam_write_data(wdat8),
      .cam_write_req_tag_flags(wtf8), .cam_write_tag(tag8), .cam_write_flags(flg8)
   );

   wire        s_ready = sel8 ? ready8 : ready4;
   wire        s_busy  = sel8 ? busy8  : busy4;
   wire        s_iv    = sel8 ? iv8    : iv4;
   wire        s_exc   = sel8 ? exc8   : exc4;
   wire        s_cv    = sel8 ? cv8    : cv4;
   wire        s_cmd   = sel8 ? cmd8   : cmd4;
   wire        s_rr    = sel8 ? rr8    : rr4;
   wire        s_eack  = sel8 ? eack8  : eack4;
   wire        s_wd    = sel8 ? wd8    : wd4;
   wire        s_wtf   = sel8 ? wtf8   : wtf4;
   wire [31:0] s_insn  = sel8 ? insn8  : insn4;
   wire [31:0] s_wdat  = sel8 ? wdat8  : wdat4;
   wire [26:0] s_addr  = sel8 ? addr8  : addr4;
   wire [9:0]  s_idx   = sel8 ? idx8   : idx4;
   wire [16:0] s_tag   = sel8 ? tag8   : tag4;
   wire [1:0]  s_flg   = sel8 ? flg8   : flg4;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_core);
      #1;
   endtask

   // Accept a request and pass through CMD with a zero-wait cready.
   task automatic start(input logic [26:0] a, input string tag);
      req_valid = 1'b1;
      req_addr  = a;
      cready    = 1'b1;
      #1;
      chk({tag, " req_ready"}, 32'(s_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      #1;
      chk({tag, " cvalid"}, 32'(s_cv), 32'd1);
      chk({tag, " addr"}, 32'(s_addr), 32'(a));
      tick();
      cready = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d, input logic last, input logic k,
                       input logic [9:0] eidx, input logic eiv, input logic etf,
                       input logic [1:0] eflg, input string tag);
      rvalid = 1'b1;
      rdata  = d;
      rlast  = last;
      kill   = k;
      #1;
      chk({tag, " rready"}, 32'(s_rr), 32'd1);
      chk({tag, " wr_data"}, 32'(s_wd), 32'd1);
      chk({tag, " index"}, 32'(s_idx), 32'(eidx));
      chk({tag, " wdata"}, s_wdat, d);
      chk({tag, " insn_valid"}, 32'(s_iv), 32'(eiv));
      if (eiv) chk({tag, " insn"}, s_insn, d);
      chk({tag, " wr_tf"}, 32'(s_wtf), 32'(etf));
      if (etf) chk({tag, " flags"}, 32'(s_flg), 32'(eflg));
      chk({tag, " exc"}, 32'(s_exc), 32'd0);
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
      kill   = 1'b0;
   endtask

   task automatic expect_idle(input string tag);
      #1;
      chk({tag, " idle ready"}, 32'(s_ready), 32'd1);
      chk({tag, " idle busy"}, 32'(s_busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; kill = 1'b0; cready = 1'b0; rvalid = 1'b0;
      rlast = 1'b0; error = 1'b0; req_addr = '0; rdata = '0;
      #1;
      chk("rst req_ready", 32'(ready4), 32'd1);
      chk("rst cmd", 32'(cmd4), 32'd1);
      chk("rst busy", 32'(busy4), 32'd0);
      chk("rst cvalid", 32'(cv4), 32'd0);
      chk("rst rready", 32'(rr4), 32'd0);
      chk("rst wr_data", 32'(wd4), 32'd0);
      chk("rst wr_tf", 32'(wtf4), 32'd0);
      chk("rst insn_valid", 32'(iv4), 32'd0);
      chk("rst eack", 32'(eack4), 32'd0);
      chk("rst addr", 32'(addr4), 32'd0);
      chk("rst ready8", 32'(ready8), 32'd1);
      repeat (2) @(posedge clk_core);
      @(negedge clk_core);
      reset = 1'b0;
      tick();

      // Request with coincident kill is ignored.
      req_valid = 1'b1; req_addr = 27'h00000C6; kill = 1'b1;
      tick();
      req_valid = 1'b0; kill = 1'b0;
      #1;
      chk("kill_req busy", 32'(busy4), 32'd0);
      chk("kill_req cvalid", 32'(cv4), 32'd0);
      tick();

      // Basic wrapping refill, offset 2.
      start(27'h00000C6, "basic");
      beat(32'hA0000000, 1'b0, 1'b0, 10'h0C6, 1'b1, 1'b1, 2'b00, "basic b0");
      beat(32'hA0000001, 1'b0, 1'b0, 10'h0C7, 1'b0, 1'b0, 2'b00, "basic b1");
      beat(32'hA0000002, 1'b0, 1'b0, 10'h0C4, 1'b0, 1'b0, 2'b00, "basic b2");
      beat(32'hA0000003, 1'b1, 1'b0, 10'h0C5, 1'b0, 1'b1, 2'b01, "basic b3");
      expect_idle("basic");

      // cready stalled three cycles; rvalid driven during the stall.
      req_valid = 1'b1; req_addr = 27'h12345C6; cready = 1'b0;
      tick();
      req_valid = 1'b0; rvalid = 1'b1; rdata = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall cvalid", 32'(cv4), 32'd1);
         chk("stall addr", 32'(addr4), 32'h12345C6);
         chk("stall wr_data", 32'(wd4), 32'd0);
         chk("stall rready", 32'(rr4), 32'd0);
         tick();
      end
      rvalid = 1'b0; cready = 1'b1;
      #1;
      chk("stall cvalid go", 32'(cv4), 32'd1);
      tick();
      cready = 1'b0;
      #1;
      chk("stall tag", 32'(tag4), 32'h048D1);
      beat(32'hB0, 1'b0, 1'b0, 10'h1C6, 1'b1, 1'b1, 2'b00, "stall b0");
      beat(32'hB1, 1'b0, 1'b0, 10'h1C7, 1'b0, 1'b0, 2'b00, "stall b1");
      beat(32'hB2, 1'b0, 1'b0, 10'h1C4, 1'b0, 1'b0, 2'b00, "stall b2");
      beat(32'hB3, 1'b1, 1'b0, 10'h1C5, 1'b0, 1'b1, 2'b01, "stall b3");
      expect_idle("stall");

      // Kill on the third beat: line drained, never validated.
      start(27'h00000C6, "killmid");
      beat(32'hC0, 1'b0, 1'b0, 10'h0C6, 1'b1, 1'b1, 2'b00, "killmid b0");
      beat(32'hC1, 1'b0, 1'b0, 10'h0C7, 1'b0, 1'b0, 2'b00, "killmid b1");
      beat(32'hC2, 1'b0, 1'b1, 10'h0C4, 1'b0, 1'b0, 2'b00, "killmid b2");
      beat(32'hC3, 1'b1, 1'b0, 10'h0C5, 1'b0, 1'b0, 2'b00, "killmid b3");
      expect_idle("killmid");

      // Kill with the critical beat: no delivery, invalidate still written.
      start(27'h00000C6, "killfirst");
      beat(32'hD0, 1'b0, 1'b1, 10'h0C6, 1'b0, 1'b1, 2'b00, "killfirst b0");
      beat(32'hD1, 1'b0, 1'b0, 10'h0C7, 1'b0, 1'b0, 2'b00, "killfirst b1");
      beat(32'hD2, 1'b0, 1'b0, 10'h0C4, 1'b0, 1'b0, 2'b00, "killfirst b2");
      beat(32'hD3, 1'b1, 1'b0, 10'h0C5, 1'b0, 1'b0, 2'b00, "killfirst b3");
      expect_idle("killfirst");

      // Bus error on beat 1.
      start(27'h00000C6, "err");
      beat(32'hE0, 1'b0, 1'b0, 10'h0C6, 1'b1, 1'b1, 2'b00, "err b0");
      error = 1'b1;
      #1;
      chk("err eack", 32'(eack4), 32'd1);
      chk("err exc", 32'(exc4), 32'd1);
      chk("err wr_tf", 32'(wtf4), 32'd0);
      tick();
      error = 1'b0;
      expect_idle("err");

      // Bus error on a killed refill: acknowledged, no exception.
      req_valid = 1'b1; req_addr = 27'h00000C6; cready = 1'b0;
      tick();
      req_valid = 1'b0; kill = 1'b1; cready = 1'b1;
      #1;
      chk("kerr cvalid", 32'(cv4), 32'd1);
      tick();
      kill = 1'b0; cready = 1'b0;
      beat(32'hF0, 1'b0, 1'b0, 10'h0C6, 1'b0, 1'b1, 2'b00, "kerr b0");
      error = 1'b1;
      #1;
      chk("kerr eack", 32'(eack4), 32'd1);
      chk("kerr exc", 32'(exc4), 32'd0);
      tick();
      error = 1'b0;
      expect_idle("kerr");

      // Eight-word line, offset 7, full burst.
      sel8 = 1'b1;
      start(27'h00000CF, "w8");
      beat(32'h80, 1'b0, 1'b0, 10'h0CF, 1'b1, 1'b1, 2'b00, "w8 b0");
      beat(32'h81, 1'b0, 1'b0, 10'h0C8, 1'b0, 1'b0, 2'b00, "w8 b1");
      beat(32'h82, 1'b0, 1'b0, 10'h0C9, 1'b0, 1'b0, 2'b00, "w8 b2");
      beat(32'h83, 1'b0, 1'b0, 10'h0CA, 1'b0, 1'b0, 2'b00, "w8 b3");
      beat(32'h84, 1'b0, 1'b0, 10'h0CB, 1'b0, 1'b0, 2'b00, "w8 b4");
      beat(32'h85, 1'b0, 1'b0, 10'h0CC, 1'b0, 1'b0, 2'b00, "w8 b5");
      beat(32'h86, 1'b0, 1'b0, 10'h0CD, 1'b0, 1'b0, 2'b00, "w8 b6");
      beat(32'h87, 1'b1, 1'b0, 10'h0CE, 1'b0, 1'b1, 2'b01, "w8 b7");
      expect_idle("w8");

      // Eight-word line with rlast early on beat 5.
      start(27'h00000CF, "w8short");
      beat(32'h90, 1'b0, 1'b0, 10'h0CF, 1'b1, 1'b1, 2'b00, "w8short b0");
      beat(32'h91, 1'b0, 1'b0, 10'h0C8, 1'b0, 1'b0, 2'b00, "w8short b1");
      beat(32'h92, 1'b0, 1'b0, 10'h0C9, 1'b0, 1'b0, 2'b00, "w8short b2");
      beat(32'h93, 1'b0, 1'b0, 10'h0CA, 1'b0, 1'b0, 2'b00, "w8short b3");
      beat(32'h94, 1'b0, 1'b0, 10'h0CB, 1'b0, 1'b0, 2'b00, "w8short b4");
      beat(32'h95, 1'b1, 1'b0, 10'h0CC, 1'b0, 1'b0, 2'b00, "w8short b5");
      expect_idle("w8short");
      chk("w8short cmd", 32'(s_cmd), 32'd1);
      sel8 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
